mem_burst_reader: RTL and testbench

Initiator-side counterpart of the `memory` model, used by instruction fetch and the bench loaders. It accepts a start request (base address and burst size code) and drives the memory's enable/addr/access_size/rd_wr pins. It captures the returned beats into an internal FIFO and presents them to a downstream consumer over valid/ready. Bursts are issued only when the FIFO can absorb every beat, because the memory cannot be stalled mid-burst.

---
 rtl/mem_pkg.sv | 36 +++
 rtl/burst_fifo.sv | 62 ++++++
 rtl/mem_burst_reader.sv | 174 +++++++++++++++++
 tb/tb_mem_burst_reader.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory initiator side: access-size codes, reader
// FSM states, the buffered beat record and the burst-length decode.
package mem_pkg;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;
    localparam logic [MEM_ADDR_W-1:0] MEM_TEXT_BASE = 32'h8002_0000;

    typedef enum logic [1:0] {
        SZ_1W  = 2'd0,
        SZ_4W  = 2'd1,
        SZ_8W  = 2'd2,
        SZ_16W = 2'd3
    } access_size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_SPACE,
        ST_BURST
    } rd_state_e;

    typedef struct packed {
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] data;
    } beat_t;

    function automatic logic [4:0] burst_len(input access_size_e size);
        case (size)
            SZ_1W:   burst_len = 5'd1;
            SZ_4W:   burst_len = 5'd4;
            SZ_8W:   burst_len = 5'd8;
            default: burst_len = 5'd16;
        endcase
    endfunction

endpackage

// File: rtl/burst_fifo.sv
// Synchronous FIFO of address-tagged beats; FIFO_DEPTH must be a power of two
// so the pointers wrap for free. Simultaneous push and pop are both honoured.
module burst_fifo
    import mem_pkg::*;
#(
    parameter int FIFO_DEPTH = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  beat_t                       push_beat,
    input  logic                        pop,
    output beat_t                       head_beat,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] free
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    beat_t             mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_ok, pop_ok;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign free      = CNT_W'(FIFO_DEPTH) - count_q;
    assign head_beat = mem_q[rd_ptr_q];

    // NOTE: every always_comb output is given a value on every path, so no latches.
    always_comb begin
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
        count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    // NOTE: state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_beat;
        end
    end

endmodule

// File: rtl/mem_burst_reader.sv
// Burst read initiator: issues bursts only when the beat FIFO can absorb them all.
// Define MEM_BURST_PREFETCH_EN to stream sequential bursts after the first start.
module mem_burst_reader
    import mem_pkg::*;
#(
    parameter int FIFO_DEPTH = 32,
    parameter int ADDR_W     = MEM_ADDR_W,
    parameter int DATA_W     = MEM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [1:0]        start_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_rd_wr,
    output logic              mem_enable,
    output logic [1:0]        mem_access_size,
    input  logic [DATA_W-1:0] mem_dout,
    input  logic              mem_busy,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int AV_W  = CNT_W + 1;

    rd_state_e         state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    access_size_e      size_q, size_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    access_size_e      mem_size_q, mem_size_d;
    logic              mem_enable_q, mem_enable_d;
    logic [4:0]        cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              push, pop, retire;
    logic              fifo_full, fifo_empty;
    beat_t             push_beat, head_beat;
    logic [CNT_W-1:0]  fifo_free;
    logic [AV_W-1:0]   avail;
    logic [4:0]        n_len;

    assign n_len = burst_len(size_q);
    assign pop   = out_valid && out_ready;
    // A word popped this cycle frees its slot in time for the burst's first beat.
    assign avail = {1'b0, fifo_free} + AV_W'(pop);

    always_comb begin
        state_d        = state_q;
        base_d         = base_q;
        size_d         = size_q;
        mem_addr_d     = mem_addr_q;
        mem_size_d     = mem_size_q;
        mem_enable_d   = mem_enable_q;
        cnt_d          = cnt_q;
        done_d         = 1'b0;
        err_d          = err_q;
        push           = 1'b0;
        retire         = 1'b0;
        push_beat.addr = mem_addr_q + ADDR_W'({cnt_q - 5'd1, 2'b00});
        push_beat.data = mem_dout;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d = start_addr;
                    size_d = access_size_e'(start_size);
                    if (start_addr[1:0] != 2'b00) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ST_WAIT_SPACE;
                    end
                end
            end
            ST_WAIT_SPACE: begin
                if (avail >= AV_W'(n_len)) begin
                    state_d      = ST_BURST;
                    mem_enable_d = 1'b1;
                    mem_addr_d   = base_q;
                    mem_size_d   = size_q;
                    cnt_d        = '0;
                end
            end
            ST_BURST: begin
                // cnt_q is the cycle index within the burst; beat cnt_q-1 is on mem_dout.
                if (cnt_q <= n_len) begin
                    if (cnt_q == n_len - 5'd1) begin
                        mem_enable_d = 1'b0;
                        done_d       = 1'b1;
                    end
                    push = (cnt_q != 5'd0) && !fifo_full;
                    if (cnt_q == n_len) begin
                        if (mem_busy) begin
                            cnt_d = n_len + 5'd1;
                        end else begin
                            retire = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end else if (!mem_busy) begin
                    retire = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (retire) begin
`ifdef MEM_BURST_PREFETCH_EN
            base_d  = base_q + ADDR_W'({n_len, 2'b00});
            state_d = ST_WAIT_SPACE;
`else
            state_d = ST_IDLE;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            base_q       <= '0;
            size_q       <= SZ_1W;
            mem_addr_q   <= '0;
            mem_size_q   <= SZ_1W;
            mem_enable_q <= 1'b0;
            cnt_q        <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            size_q       <= size_d;
            mem_addr_q   <= mem_addr_d;
            mem_size_q   <= mem_size_d;
            mem_enable_q <= mem_enable_d;
            cnt_q        <= cnt_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    burst_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_beat (push_beat),
        .pop       (pop),
        .head_beat (head_beat),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .free      (fifo_free)
    );

    assign mem_addr        = mem_addr_q;
    assign mem_access_size = mem_size_q;
    assign mem_enable      = mem_enable_q;
    assign mem_rd_wr       = 1'b1;
    assign mem_din         = '0;
    assign out_valid       = !fifo_empty;
    assign out_data        = head_beat.data;
    assign out_addr        = head_beat.addr;
    assign done            = done_q;
    assign err             = err_q;

endmodule

// File: tb/tb_mem_burst_reader.sv
// Scoreboard bench for mem_burst_reader: a behavioural memory answers bursts,
// expected beats are queued at start time and a monitor checks every pop.
`timescale 1ns/1ps
module tb_mem_burst_reader;
    import mem_pkg::*;

    localparam int FIFO_DEPTH = 32;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] start_addr = '0;
    logic [1:0]        start_size = '0;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic              mem_rd_wr;
    logic              mem_enable;
    logic [1:0]        mem_access_size;
    logic [DATA_W-1:0] mem_dout = '0;
    logic              mem_busy = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              done;
    logic              err;

    mem_burst_reader #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .start_addr      (start_addr),
        .start_size      (start_size),
        .mem_addr        (mem_addr),
        .mem_din         (mem_din),
        .mem_rd_wr       (mem_rd_wr),
        .mem_enable      (mem_enable),
        .mem_access_size (mem_access_size),
        .mem_dout        (mem_dout),
        .mem_busy        (mem_busy),
        .out_data        (out_data),
        .out_addr        (out_addr),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .done            (done),
        .err             (err)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_fail = 0;
    beat_t      sb_q[$];
    int         en_cycles = 0;
    int         done_cnt = 0;
    int         words_out = 0;
    logic       done_prev = 1'b0;
    logic [1:0] exp_size = 2'd0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h0055_AA00;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory model: beat k of a burst appears on mem_dout in the cycle after enable cycle k.
    initial begin : mem_model
        int          idx;
        logic [31:0] base;
        logic [31:0] nxt;
        idx  = 0;
        base = '0;
        forever begin
            @(negedge clk);
            nxt = 32'hDEAD_BEEF;
            if (mem_enable) begin
                if (idx == 0) begin
                    base = mem_addr;
                    check("access_size", 64'(mem_access_size), 64'(exp_size));
                    check("rd_wr", 64'(mem_rd_wr), 64'd1);
                end else begin
                    check("addr_hold", 64'(mem_addr), 64'(base));
                end
                nxt = mem_word(base + 32'(idx * 4));
                idx++;
            end else begin
                idx = 0;
            end
            @(posedge clk);
            #1;
            mem_dout = nxt;
        end
    end

    initial begin : monitor
        beat_t exp;
        forever begin
            @(negedge clk);
            if (mem_enable) en_cycles++;
            if (done) begin
                check("done_single", 64'(done_prev), 64'd0);
                check("done_enable_low", 64'(mem_enable), 64'd0);
                done_cnt++;
            end
            done_prev = done;
            if (out_valid && out_ready && rst_n) begin
                check("sb_nonempty", 64'(sb_q.size() > 0), 64'd1);
                if (sb_q.size() > 0) begin
                    exp = sb_q.pop_front();
                    check("out_addr", 64'(out_addr), 64'(exp.addr));
                    check("out_data", 64'(out_data), 64'(exp.data));
                    words_out++;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        mem_busy  = 1'b0;
        sb_q.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic issue_start(input logic [31:0] addr, input logic [1:0] size, input bit accept);
        beat_t b;
        int    n;
        start      = 1'b1;
        start_addr = addr;
        start_size = size;
        if (accept) begin
            exp_size = size;
            n = int'(burst_len(access_size_e'(size)));
            for (int k = 0; k < n; k++) begin
                b.addr = addr + 32'(4 * k);
                b.data = mem_word(b.addr);
                sb_q.push_back(b);
            end
        end
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0;
        bit got;
        d0  = done_cnt;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (done_cnt != d0) begin
                got = 1'b1;
                break;
            end
        end
        check(name, 64'(got), 64'd1);
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int i = 0; i < budget && sb_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        repeat (2) @(posedge clk);
        #1;
        check(name, 64'(sb_q.size()), 64'd0);
        check({name, "_empty"}, 64'(out_valid), 64'd0);
    endtask

    int e0, d0, w0;

    initial begin : stimulus
        // Reset state
        #12;
        check("rst_enable", 64'(mem_enable), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_rd_wr", 64'(mem_rd_wr), 64'd1);
        check("rst_addr", 64'(mem_addr), 64'd0);
        check("rst_size", 64'(mem_access_size), 64'd0);
        check("rst_din", 64'(mem_din), 64'd0);
        do_reset();

        // Single-word burst with a ready consumer
        e0 = en_cycles; d0 = done_cnt; w0 = words_out;
        out_ready = 1'b1;
        issue_start(MEM_TEXT_BASE, 2'd0, 1'b1);
        wait_done("t1_done", 50);
        wait_drain("t1_drain", 50);
        check("t1_en_cycles", 64'(en_cycles - e0), 64'd1);
        check("t1_done_cnt", 64'(done_cnt - d0), 64'd1);
        check("t1_words", 64'(words_out - w0), 64'd1);

        // 16-word burst buffered with the consumer stalled
        e0 = en_cycles; d0 = done_cnt; w0 = words_out;
        out_ready = 1'b0;
        issue_start(MEM_TEXT_BASE, 2'd3, 1'b1);
        wait_done("t2_done", 60);
        repeat (3) @(posedge clk);
        #1;
        check("t2_en_cycles", 64'(en_cycles - e0), 64'd16);
        check("t2_done_cnt", 64'(done_cnt - d0), 64'd1);
        check("t2_buffered", 64'(out_valid), 64'd1);
        check("t2_no_pop", 64'(words_out - w0), 64'd0);
        out_ready = 1'b1;
        wait_drain("t2_drain", 60);
        check("t2_words", 64'(words_out - w0), 64'd16);

        // Space check: 20 buffered, a 16-word burst must wait for 4 pops
        w0 = words_out;
        out_ready = 1'b0;
        issue_start(MEM_TEXT_BASE + 32'h100, 2'd3, 1'b1);
        wait_done("t3_done_a", 60);
        issue_start(MEM_TEXT_BASE + 32'h200, 2'd1, 1'b1);
        wait_done("t3_done_b", 60);
        e0 = en_cycles; d0 = done_cnt;
        issue_start(MEM_TEXT_BASE + 32'h300, 2'd3, 1'b1);
        repeat (30) @(posedge clk);
        #1;
        check("t3_wait_en", 64'(en_cycles - e0), 64'd0);
        check("t3_wait_enable", 64'(mem_enable), 64'd0);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("t3_three_pops_en", 64'(en_cycles - e0), 64'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        wait_done("t3_done_c", 60);
        check("t3_en_cycles", 64'(en_cycles - e0), 64'd16);
        check("t3_popped", 64'(words_out - w0), 64'd4);
        out_ready = 1'b1;
        wait_drain("t3_drain", 100);
        check("t3_words", 64'(words_out - w0), 64'd36);

        // Misaligned starts set the sticky error and issue nothing
        for (int off = 1; off <= 3; off++) begin
            do_reset();
            check("t4_err_cleared", 64'(err), 64'd0);
            e0 = en_cycles; d0 = done_cnt;
            issue_start(MEM_TEXT_BASE + 32'(off), 2'd0, 1'b0);
            repeat (20) @(posedge clk);
            #1;
            check("t4_err", 64'(err), 64'd1);
            check("t4_no_enable", 64'(en_cycles - e0), 64'd0);
            check("t4_no_done", 64'(done_cnt - d0), 64'd0);
            check("t4_no_valid", 64'(out_valid), 64'd0);
        end
        out_ready = 1'b1;
        issue_start(MEM_TEXT_BASE + 32'h40, 2'd0, 1'b1);
        wait_done("t4_after_err_done", 50);
        wait_drain("t4_after_err_drain", 50);
        check("t4_err_sticky", 64'(err), 64'd1);

        // Asynchronous reset mid-burst, then a clean 4-word burst
        do_reset();
        e0 = en_cycles;
        issue_start(MEM_TEXT_BASE + 32'h500, 2'd2, 1'b1);
        for (int i = 0; i < 40 && (en_cycles - e0) < 5; i++) begin
            @(posedge clk);
            #1;
        end
        check("t5_reached_beat5", 64'(en_cycles - e0 >= 5), 64'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        sb_q.delete();
        #1;
        check("t5_async_enable", 64'(mem_enable), 64'd0);
        check("t5_async_valid", 64'(out_valid), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        w0 = words_out;
        out_ready = 1'b1;
        issue_start(MEM_TEXT_BASE + 32'h600, 2'd1, 1'b1);
        wait_done("t5_done", 50);
        wait_drain("t5_drain", 50);
        check("t5_words", 64'(words_out - w0), 64'd4);

        // mem_busy held past the final beat delays retirement; starts meanwhile are dropped
        e0 = en_cycles; w0 = words_out;
        out_ready = 1'b1;
        mem_busy  = 1'b1;
        issue_start(MEM_TEXT_BASE + 32'h700, 2'd0, 1'b1);
        wait_done("t6_done_a", 50);
        issue_start(MEM_TEXT_BASE + 32'h800, 2'd0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("t6_busy_hold_en", 64'(en_cycles - e0), 64'd1);
        mem_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        issue_start(MEM_TEXT_BASE + 32'h900, 2'd0, 1'b1);
        wait_done("t6_done_b", 50);
        wait_drain("t6_drain", 50);
        check("t6_en_cycles", 64'(en_cycles - e0), 64'd2);
        check("t6_words", 64'(words_out - w0), 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
